// File: rtl/interpolating_lut_programmer.sv
// -----------------------------------------------------------------------------
// interpolating_lut_programmer
//
// Transmit side of the interpolating LUT programming port. A CPU-writable
// shadow table is streamed, on a start pulse, in address order over a
// valid/ready link into the LUT core. The block then waits for the core's
// done flag and reports busy / done / timeout status.
//
// Ports
//   clk                  clock
//   reset                asynchronous, active-low reset
//   enable               0 = synchronous abort to idle (shadow table kept)
//   cfg_wr_addr/data/en  shadow table write port, accepted only while idle
//   start                single-cycle pulse that begins a load
//   busy                 high from accepted start until idle is re-entered
//   done                 last load completed OK (cleared by next start)
//   timeout_err          sticky: core done flag not seen in time
//   wr_busy_err          sticky: table write attempted while busy (dropped)
//   lut_prog_dout        table word to LUT core
//   lut_prog_dout_valid  word valid
//   lut_prog_dout_ready  core accepts word
//   lut_prog_done        core reports table fully loaded
// -----------------------------------------------------------------------------
module interpolating_lut_programmer #(
    parameter int G_ADDR_WIDTH   = 10,
    parameter int G_NUM_ENTRIES  = 2**G_ADDR_WIDTH,
    parameter int G_DWIDTH       = 24,
    parameter int G_DONE_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [G_ADDR_WIDTH-1:0] cfg_wr_addr,
    input  logic [G_DWIDTH-1:0]     cfg_wr_data,
    input  logic                    cfg_wr_en,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err,
    output logic                    wr_busy_err,
    output logic [G_DWIDTH-1:0]     lut_prog_dout,
    output logic                    lut_prog_dout_valid,
    input  logic                    lut_prog_dout_ready,
    input  logic                    lut_prog_done
);

    localparam int C_AW = G_ADDR_WIDTH + 1;
    localparam int C_TW = $clog2(G_DONE_TIMEOUT + 1);

    localparam logic [C_AW-1:0] C_NUM     = C_AW'(G_NUM_ENTRIES);
    localparam logic [C_AW-1:0] C_LAST    = C_AW'(G_NUM_ENTRIES - 1);
    localparam logic [C_AW-1:0] C_ONE_A   = C_AW'(1);
    localparam logic [C_TW-1:0] C_TO_LAST = C_TW'(G_DONE_TIMEOUT - 1);
    localparam logic [C_TW-1:0] C_ONE_T   = C_TW'(1);

    typedef enum logic [1:0] {
        SM_IDLE      = 2'd0,
        SM_STREAM    = 2'd1,
        SM_WAIT_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Address counters are one bit wider than the table address so that a
    // full 2**G_ADDR_WIDTH table terminates without wrapping.
    logic [C_AW-1:0]     rd_addr_q, rd_addr_d;
    logic [C_AW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [C_TW-1:0]     to_cnt_q, to_cnt_d;

    logic                r1_vld_q, r1_vld_d;
    logic [G_DWIDTH-1:0] dout_q, dout_d;
    logic                vld_q, vld_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                to_err_q, to_err_d;
    logic                wb_err_q, wb_err_d;

    // Cleared by reset and set on the first clock afterwards: a start that is
    // already high on the edge coinciding with reset release is not taken.
    logic                armed_q;

    logic [G_DWIDTH-1:0] mem_q [2**G_ADDR_WIDTH];
    logic [G_DWIDTH-1:0] ram_rdata_q;
    logic                ram_rd_en;
    logic                ram_wr_en;

    logic                xfer;
    logic                slot_free;
    logic                consume;

    // Shadow table: synchronous write, 1-cycle registered read.
    always_ff @(posedge clk) begin
        if (ram_wr_en) begin
            mem_q[cfg_wr_addr] <= cfg_wr_data;
        end
        if (ram_rd_en) begin
            ram_rdata_q <= mem_q[rd_addr_q[G_ADDR_WIDTH-1:0]];
        end
    end

    // Two-deep prefetch: RAM output register (r1) feeds the output register.
    // The output register reloads whenever it is empty or being emptied, and
    // a new read is issued whenever r1 will be free, giving one word per
    // clock under continuous ready.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        tx_cnt_d  = tx_cnt_q;
        to_cnt_d  = to_cnt_q;
        r1_vld_d  = r1_vld_q;
        dout_d    = dout_q;
        vld_d     = vld_q;
        busy_d    = busy_q;
        done_d    = done_q;
        to_err_d  = to_err_q;
        wb_err_d  = wb_err_q;
        ram_rd_en = 1'b0;
        ram_wr_en = 1'b0;
        xfer      = vld_q & lut_prog_dout_ready;
        slot_free = ~vld_q | xfer;
        consume   = 1'b0;

        case (state_q)
            SM_IDLE: begin
                ram_wr_en = cfg_wr_en;
                if (start && enable && armed_q) begin
                    state_d   = SM_STREAM;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    to_err_d  = 1'b0;
                    wb_err_d  = 1'b0;
                    rd_addr_d = '0;
                    tx_cnt_d  = '0;
                    r1_vld_d  = 1'b0;
                    vld_d     = 1'b0;
                end
            end

            SM_STREAM: begin
                if (cfg_wr_en) begin
                    wb_err_d = 1'b1;
                end
                consume = slot_free & r1_vld_q;
                if (consume) begin
                    dout_d = ram_rdata_q;
                    vld_d  = 1'b1;
                end
                if (rd_addr_q < C_NUM && (!r1_vld_q || consume)) begin
                    ram_rd_en = 1'b1;
                    rd_addr_d = rd_addr_q + C_ONE_A;
                    r1_vld_d  = 1'b1;
                end else if (consume) begin
                    r1_vld_d = 1'b0;
                end
                if (xfer) begin
                    tx_cnt_d = tx_cnt_q + C_ONE_A;
                    if (tx_cnt_q == C_LAST) begin
                        state_d  = SM_WAIT_DONE;
                        vld_d    = 1'b0;
                        to_cnt_d = '0;
                    end
                end
            end

            SM_WAIT_DONE: begin
                if (cfg_wr_en) begin
                    wb_err_d = 1'b1;
                end
                // Done takes priority over a timeout on the same cycle.
                if (lut_prog_done) begin
                    state_d = SM_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (to_cnt_q == C_TO_LAST) begin
                    state_d  = SM_IDLE;
                    to_err_d = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + C_ONE_T;
                end
            end

            default: begin
                state_d = SM_IDLE;
                vld_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides everything; sticky error flags are left alone.
        if (!enable) begin
            state_d   = SM_IDLE;
            vld_d     = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            r1_vld_d  = 1'b0;
            ram_rd_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SM_IDLE;
            rd_addr_q <= '0;
            tx_cnt_q  <= '0;
            to_cnt_q  <= '0;
            r1_vld_q  <= 1'b0;
            dout_q    <= '0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            to_err_q  <= 1'b0;
            wb_err_q  <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            tx_cnt_q  <= tx_cnt_d;
            to_cnt_q  <= to_cnt_d;
            r1_vld_q  <= r1_vld_d;
            dout_q    <= dout_d;
            vld_q     <= vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            to_err_q  <= to_err_d;
            wb_err_q  <= wb_err_d;
            armed_q   <= 1'b1;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign timeout_err         = to_err_q;
    assign wr_busy_err         = wb_err_q;
    assign lut_prog_dout       = dout_q;
    assign lut_prog_dout_valid = vld_q;

endmodule
